video_timing_gen: RTL

// - Parametrised raster timing generator for arcade cores; successor to the fixed-count HVGEN.
// - Runs on clk_sys with a pixel-clock enable, not a derived clock.
// - Outputs pixel position (HPOS/VPOS) to the game core, plus blank/sync and a blanked RGB to arcade_video.
// - Adds: runtime H/V sync-position offset (screen centring), frame-boundary latching of that offset,

---
 rtl/vtg_pkg.sv | 36 +++
 rtl/vtg_axis_counter.sv | 89 ++++++++
 rtl/video_timing_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vtg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vtg_pkg
// Description : Shared definitions for the video timing generator: default
//               NinjaKun raster timing, the sync-offset type and the
//               half-open window compare helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vtg_pkg;

    // Default NinjaKun raster timing (counts in pixel clocks / lines)
    localparam int c_RGB_W        = 12;
    localparam int c_CNT_W        = 9;
    localparam int c_H_TOTAL      = 384;
    localparam int c_H_ACT_START  = 16;
    localparam int c_H_ACT_END    = 272;
    localparam int c_H_SYNC_START = 295;
    localparam int c_H_SYNC_END   = 327;
    localparam int c_V_TOTAL      = 263;
    localparam int c_V_ACT_START  = 16;
    localparam int c_V_ACT_END    = 208;
    localparam int c_V_SYNC_START = 235;
    localparam int c_V_SYNC_END   = 242;

    // Signed screen-centring shift, -8..+7
    typedef logic signed [3:0] sync_off_t;

    // Half-open window test lo <= cnt < hi; callers zero-extend to 16 bits
    function automatic logic in_window(input logic [15:0] cnt,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vtg_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vtg_axis_counter
// Description : One raster axis: counter wrapping at TOTAL, wrap carry-out,
//               registered blank and active-low sync with a signed offset on
//               the sync window.
// Ports       : clk, rst_n      clock, asynchronous active-low reset
//               i_ce            update enable for blank/sync registers
//               i_step          count advance enable
//               i_off[3:0]      signed sync shift (already frame-latched)
//               o_cnt           current count
//               o_wrap          i_step while count is TOTAL-1
//               o_blank_nxt     blank decode of the current count
//               o_blank         registered blank, active-high
//               o_sync_n        registered sync, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module vtg_axis_counter
    import vtg_pkg::*;
#(
    parameter int CNT_W      = c_CNT_W,
    parameter int TOTAL      = c_H_TOTAL,
    parameter int ACT_START  = c_H_ACT_START,
    parameter int ACT_END    = c_H_ACT_END,
    parameter int SYNC_START = c_H_SYNC_START,
    parameter int SYNC_END   = c_H_SYNC_END
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ce,
    input  logic             i_step,
    input  logic [3:0]       i_off,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap,
    output logic             o_blank_nxt,
    output logic             o_blank,
    output logic             o_sync_n
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TOTAL - 1);

    // The shifted sync window must stay inside 0..TOTAL-1 for every offset,
    // since the bounds are deliberately not wrapped modulo TOTAL.
    generate
        if (CNT_W < 4 || CNT_W > 15 || TOTAL > (1 << CNT_W) ||
            SYNC_START < 8 || SYNC_END + 7 > TOTAL) begin : g_bad_params
            $error("vtg_axis_counter: sync window leaves 0..TOTAL-1 for some offset");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             r_blank;
    logic             r_sync_n;
    logic [CNT_W:0]   w_off_ext;
    logic [CNT_W:0]   w_sync_lo;
    logic [CNT_W:0]   w_sync_hi;
    logic             w_sync_nxt;

    // Bounds carry one extra bit so SYNC_END+offset cannot alias
    assign w_off_ext   = {{(CNT_W-3){i_off[3]}}, i_off};
    assign w_sync_lo   = (CNT_W+1)'(SYNC_START) + w_off_ext;
    assign w_sync_hi   = (CNT_W+1)'(SYNC_END) + w_off_ext;

    assign o_wrap      = i_step && (r_cnt == c_LAST);
    assign o_blank_nxt = !in_window(16'(r_cnt), 16'(ACT_START), 16'(ACT_END));
    assign w_sync_nxt  = in_window(16'(r_cnt), 16'(w_sync_lo), 16'(w_sync_hi));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_blank  <= 1'b1;
            r_sync_n <= 1'b1;
        end else begin
            if (i_step) begin
                r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + CNT_W'(1);
            end
            if (i_ce) begin
                r_blank  <= o_blank_nxt;
                r_sync_n <= !w_sync_nxt;
            end
        end
    end

    assign o_cnt    = r_cnt;
    assign o_blank  = r_blank;
    assign o_sync_n = r_sync_n;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Parametrised raster timing generator running on clk_sys with
//               a pixel enable. Produces pixel position, blank/sync, blanked
//               RGB, a vblank-start strobe and a per-frame field toggle.
//               H/V sync offsets are sampled only at the frame boundary.
// Ports       : clk_sys, reset_n   system clock, async active-low reset
//               ce_pix             pixel enable, all state advances on it
//               h_off, v_off       signed sync shift, -8..+7
//               iRGB / oRGB        core colour in / blanked registered out
//               HPOS, VPOS         count minus active start (combinational)
//               HBLK, VBLK         blank, active-high
//               HSYN, VSYN         sync, active-low
//               vbl_stb            one clk_sys pulse at vblank start
//               field              toggles every frame
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int RGB_W        = c_RGB_W,
    parameter int CNT_W        = c_CNT_W,
    parameter int H_TOTAL      = c_H_TOTAL,
    parameter int H_ACT_START  = c_H_ACT_START,
    parameter int H_ACT_END    = c_H_ACT_END,
    parameter int H_SYNC_START = c_H_SYNC_START,
    parameter int H_SYNC_END   = c_H_SYNC_END,
    parameter int V_TOTAL      = c_V_TOTAL,
    parameter int V_ACT_START  = c_V_ACT_START,
    parameter int V_ACT_END    = c_V_ACT_END,
    parameter int V_SYNC_START = c_V_SYNC_START,
    parameter int V_SYNC_END   = c_V_SYNC_END
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ce_pix,
    input  logic [3:0]       h_off,
    input  logic [3:0]       v_off,
    input  logic [RGB_W-1:0] iRGB,
    output logic [CNT_W-1:0] HPOS,
    output logic [CNT_W-1:0] VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             vbl_stb,
    output logic             field
);

    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    logic             w_hwrap;
    logic             w_vwrap;
    logic             w_hblk_nxt;
    logic             w_vblk_nxt;

    sync_off_t        r_hs;
    sync_off_t        r_vs;
    logic [RGB_W-1:0] r_rgb;
    logic             r_vbl_stb;
    logic             r_field;

    vtg_axis_counter #(
        .CNT_W      (CNT_W),
        .TOTAL      (H_TOTAL),
        .ACT_START  (H_ACT_START),
        .ACT_END    (H_ACT_END),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_END)
    ) u_h_axis (
        .clk         (clk_sys),
        .rst_n       (reset_n),
        .i_ce        (ce_pix),
        .i_step      (ce_pix),
        .i_off       (r_hs),
        .o_cnt       (w_hcnt),
        .o_wrap      (w_hwrap),
        .o_blank_nxt (w_hblk_nxt),
        .o_blank     (HBLK),
        .o_sync_n    (HSYN)
    );

    // Vertical count steps on the horizontal wrap, but its blank/sync
    // registers still update every pixel so both axes share one latency.
    vtg_axis_counter #(
        .CNT_W      (CNT_W),
        .TOTAL      (V_TOTAL),
        .ACT_START  (V_ACT_START),
        .ACT_END    (V_ACT_END),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_END)
    ) u_v_axis (
        .clk         (clk_sys),
        .rst_n       (reset_n),
        .i_ce        (ce_pix),
        .i_step      (w_hwrap),
        .i_off       (r_vs),
        .o_cnt       (w_vcnt),
        .o_wrap      (w_vwrap),
        .o_blank_nxt (w_vblk_nxt),
        .o_blank     (VBLK),
        .o_sync_n    (VSYN)
    );

    assign HPOS = w_hcnt - CNT_W'(H_ACT_START);
    assign VPOS = w_vcnt - CNT_W'(V_ACT_START);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hs      <= '0;
            r_vs      <= '0;
            r_rgb     <= '0;
            r_vbl_stb <= 1'b0;
            r_field   <= 1'b0;
        end else begin
            // Rising edge of the next VBLK value; self-clears next clk_sys
            r_vbl_stb <= ce_pix & w_vblk_nxt & ~VBLK;
            if (ce_pix) begin
                r_rgb <= (w_hblk_nxt | w_vblk_nxt) ? '0 : iRGB;
            end
            // w_vwrap is the last pixel of the frame: offsets take effect
            // from count 0,0 of the next frame only.
            if (w_vwrap) begin
                r_hs    <= h_off;
                r_vs    <= v_off;
                r_field <= ~r_field;
            end
        end
    end

    assign oRGB    = r_rgb;
    assign vbl_stb = r_vbl_stb;
    assign field   = r_field;

endmodule
`default_nettype wire
